acc_ctrl: RTL and testbench

//  Sequencer for the PSUM accumulator datapath. Per output tile it issues a

---
 rtl/acc_ctrl.sv | 115 +++++++++++
 tb/tb_acc_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/acc_ctrl.sv
// Sequencer for the PSUM accumulator: flushes on the first beat of each output,
// gates core beats into the adder, adds bias once and drains via valid/ready.
module acc_ctrl #(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_Start,
    input  logic              i_Clear,
    input  logic [CNT_W-1:0]  i_Num_Acc,
    input  logic [CNT_W-1:0]  i_Num_Out,
    input  logic              i_Bias_En,
    input  logic              i_Core_Vld,
    output logic              o_Core_Stall,
    output logic              o_Core_Vld,
    output logic              o_Flush,
    output logic              o_Sel_Bias_BUF,
    output logic              o_PSUM_En,
    output logic [ADDR_W-1:0] o_Bias_Addr,
    output logic              o_Out_Vld,
    input  logic              i_Out_Rdy,
    output logic              o_Busy,
    output logic              o_Done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC  = 3'd1,
        S_BIAS = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] acc_last;
    logic [CNT_W-1:0] out_last;
    logic             bias_en;
    logic             first;
    logic             beat;

    assign beat = (state == S_ACC) && i_Core_Vld;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state    <= S_IDLE;
            acc_cnt  <= '0;
            out_cnt  <= '0;
            acc_last <= '0;
            out_last <= '0;
            bias_en  <= 1'b0;
            first    <= 1'b0;
        end else if (i_Clear) begin
            state   <= S_IDLE;
            acc_cnt <= '0;
            out_cnt <= '0;
            first   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_Start) begin
                        // Zero counts are stored as "last index 0", i.e. treated as one
                        acc_last <= (i_Num_Acc == '0) ? '0 : i_Num_Acc - CNT_W'(1);
                        out_last <= (i_Num_Out == '0) ? '0 : i_Num_Out - CNT_W'(1);
                        bias_en  <= i_Bias_En;
                        acc_cnt  <= '0;
                        out_cnt  <= '0;
                        first    <= 1'b1;
                        state    <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (beat) begin
                        first <= 1'b0;
                        if (acc_cnt == acc_last) begin
                            acc_cnt <= '0;
                            state   <= bias_en ? S_BIAS : S_OUT;
                        end else begin
                            acc_cnt <= acc_cnt + CNT_W'(1);
                        end
                    end
                end
                S_BIAS: state <= S_OUT;
                S_OUT: begin
                    if (i_Out_Rdy) begin
                        if (out_cnt == out_last) begin
                            state <= S_DONE;
                        end else begin
                            out_cnt <= out_cnt + CNT_W'(1);
                            first   <= 1'b1;
                            state   <= S_ACC;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_Core_Stall   = (state == S_BIAS) || (state == S_OUT) || (state == S_DONE);
        o_Core_Vld     = beat;
        o_Flush        = beat && first;
        o_Sel_Bias_BUF = (state == S_BIAS);
        o_PSUM_En      = beat || (state == S_BIAS);
        o_Bias_Addr    = (state == S_IDLE) ? '0 : out_cnt[ADDR_W-1:0];
        o_Out_Vld      = (state == S_OUT);
        o_Busy         = (state != S_IDLE);
        o_Done         = (state == S_DONE);
    end

endmodule

// File: tb/tb_acc_ctrl.sv
// Randomized bench for acc_ctrl against a job-progress reference model.
module tb_acc_ctrl;

    localparam int CNT_W  = 16;
    localparam int ADDR_W = 8;

    logic              i_CLK = 1'b0;
    logic              i_RST = 1'b1;
    logic              i_Start = 1'b0;
    logic              i_Clear = 1'b0;
    logic [CNT_W-1:0]  i_Num_Acc = '0;
    logic [CNT_W-1:0]  i_Num_Out = '0;
    logic              i_Bias_En = 1'b0;
    logic              i_Core_Vld = 1'b0;
    logic              i_Out_Rdy = 1'b0;
    logic              o_Core_Stall, o_Core_Vld, o_Flush, o_Sel_Bias_BUF;
    logic              o_PSUM_En, o_Out_Vld, o_Busy, o_Done;
    logic [ADDR_W-1:0] o_Bias_Addr;

    acc_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_Start(i_Start), .i_Clear(i_Clear),
        .i_Num_Acc(i_Num_Acc), .i_Num_Out(i_Num_Out), .i_Bias_En(i_Bias_En),
        .i_Core_Vld(i_Core_Vld), .o_Core_Stall(o_Core_Stall), .o_Core_Vld(o_Core_Vld),
        .o_Flush(o_Flush), .o_Sel_Bias_BUF(o_Sel_Bias_BUF), .o_PSUM_En(o_PSUM_En),
        .o_Bias_Addr(o_Bias_Addr), .o_Out_Vld(o_Out_Vld), .i_Out_Rdy(i_Out_Rdy),
        .o_Busy(o_Busy), .o_Done(o_Done)
    );

    always #5 i_CLK = ~i_CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Job-level reference: which tile, how many beats into it, and pending phases
    bit m_active, m_bias, m_wait_bias, m_wait_out, m_done;
    int m_n_acc, m_n_out, m_tile, m_beats;
    int n_dones = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_active = 0; m_bias = 0; m_wait_bias = 0; m_wait_out = 0; m_done = 0;
        m_n_acc = 0; m_n_out = 0; m_tile = 0; m_beats = 0;
    endtask

    task automatic compare();
        bit in_acc, beat;
        in_acc = m_active && !m_wait_bias && !m_wait_out && !m_done;
        beat   = in_acc && i_Core_Vld;
        check("stall",    32'(o_Core_Stall),   32'(m_active && !in_acc));
        check("core_vld", 32'(o_Core_Vld),     32'(beat));
        check("flush",    32'(o_Flush),        32'(beat && m_beats == 0));
        check("sel_bias", 32'(o_Sel_Bias_BUF), 32'(m_wait_bias));
        check("psum_en",  32'(o_PSUM_En),      32'(beat || m_wait_bias));
        check("addr",     32'(o_Bias_Addr),    m_active ? 32'(m_tile % 256) : 32'd0);
        check("out_vld",  32'(o_Out_Vld),      32'(m_wait_out));
        check("busy",     32'(o_Busy),         32'(m_active));
        check("done",     32'(o_Done),         32'(m_done));
    endtask

    task automatic model_update(input bit st, clr, vld, rdy, input int na, no, input bit be);
        if (clr) begin
            model_reset();
        end else if (m_done) begin
            m_done = 0; m_active = 0; n_dones++;
        end else if (!m_active) begin
            if (st) begin
                m_active = 1; m_bias = be;
                m_n_acc = (na == 0) ? 1 : na;
                m_n_out = (no == 0) ? 1 : no;
                m_tile = 0; m_beats = 0;
            end
        end else if (m_wait_bias) begin
            m_wait_bias = 0; m_wait_out = 1;
        end else if (m_wait_out) begin
            if (rdy) begin
                m_wait_out = 0;
                if (m_tile == m_n_out - 1) m_done = 1;
                else begin m_tile++; m_beats = 0; end
            end
        end else if (vld) begin
            m_beats++;
            if (m_beats == m_n_acc) begin
                m_beats = 0;
                if (m_bias) m_wait_bias = 1; else m_wait_out = 1;
            end
        end
    endtask

    task automatic step(input bit st, clr, vld, rdy, input int na, no, input bit be);
        i_Start = st; i_Clear = clr; i_Core_Vld = vld; i_Out_Rdy = rdy;
        i_Num_Acc = CNT_W'(na); i_Num_Out = CNT_W'(no); i_Bias_En = be;
        @(negedge i_CLK);
        compare();
        @(posedge i_CLK);
        model_update(st, clr, vld, rdy, na, no, be);
        #1;
    endtask

    task automatic async_reset();
        @(negedge i_CLK);
        #1 i_RST = 1'b1;
        #1 model_reset();
        compare();
        @(posedge i_CLK);
        #1 i_RST = 1'b0;
    endtask

    int vld_pat[5] = '{1, 0, 0, 1, 1};

    initial begin
        model_reset();
        #3 compare();
        @(posedge i_CLK);
        #1 i_RST = 1'b0;

        // 4 beats, 1 output, bias, ready held
        step(1, 0, 0, 1, 4, 1, 1);
        for (int i = 0; i < 9; i++) step(0, 0, i < 4, 1, 0, 0, 0);
        // gapped valid with 3 beats
        step(1, 0, 0, 1, 3, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 0, vld_pat[i] != 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0);
        // 3 outputs, no bias, ready withheld, stray start pulses
        step(1, 0, 0, 0, 2, 3, 0);
        for (int t = 0; t < 3; t++) begin
            step(0, 0, 1, 0, 0, 0, 0);
            step(1, 0, 1, 0, 5, 5, 1);
            for (int i = 0; i < 4; i++) step(i == 1, 0, 1, 0, 7, 7, 1);
            step(0, 0, 0, 1, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0);
        // zero counts treated as one
        step(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0, 0, 0);
        // clear during output with ready, clear beating start in idle
        step(1, 0, 0, 0, 1, 2, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0);
        step(1, 1, 1, 1, 2, 2, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // async reset mid-accumulation, then a clean job with many outputs
        step(1, 0, 0, 0, 4, 2, 1);
        step(0, 0, 1, 0, 0, 0, 0);
        async_reset();
        step(1, 0, 0, 1, 1, 5, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 0, 0, 0);

        for (int c = 0; c < 4000; c++) begin
            if (c % 900 == 450) async_reset();
            step(($urandom % (m_active ? 10 : 3)) == 0,
                 ($urandom % 200) == 0,
                 ($urandom % 3) != 0,
                 ($urandom % 2) == 0,
                 int'($urandom % 5), int'($urandom % 4), ($urandom % 2) == 1);
        end

        if (n_dones < 5) check("dones_seen", 32'(n_dones >= 5), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
